// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: register and
// counter widths, FSM state encoding, memory-wait timeout limit and a
// register-match helper in which r0 never matches.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned WAIT_W      = 8;

    localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = 8'd255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // A writer to r0 never creates a dependence.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return (dst != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard/stall controller.
//   master : pipeline (drives ID/EX/MEM fields and dmem status, reads controls)
//   slave  : controller (reads fields, drives enables, mux select, counters)
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic [REG_W-1:0]       id_rs;
    logic [REG_W-1:0]       id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic                   id_branch;
    logic [REG_W-1:0]       ex_rd;
    logic [REG_W-1:0]       mem_rd;
    logic                   ex_regwrite;
    logic                   ex_memread;
    logic                   mem_memread;
    logic                   branch_taken;
    logic                   dmem_req;
    logic                   dmem_ready;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   bubble_sel;
    logic                   ifid_flush;
    logic                   pipe_freeze;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch,
               ex_rd, mem_rd, ex_regwrite, ex_memread, mem_memread,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, bubble_sel, ifid_flush, pipe_freeze,
               stall_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch,
               ex_rd, mem_rd, ex_regwrite, ex_memread, mem_memread,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, bubble_sel, ifid_flush, pipe_freeze,
               stall_cnt, mem_timeout
    );

endinterface

// File: rtl/hazard_stall_ctrl_cmp.sv
// hazard_cmp: purely combinational dependence detection for the ID stage.
//   inputs : ID source regs and read flags, branch flag, EX/MEM dest regs and
//            their write/load control bits
//   outputs: load_use (ID needs a load still in EX),
//            br_hazard (ID branch needs a value not yet forwardable to ID)
module hazard_cmp
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_memread,
    output logic             load_use,
    output logic             br_hazard
);

    logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;

    assign ex_rs_hit  = reg_match(id_rs, ex_rd);
    assign ex_rt_hit  = reg_match(id_rt, ex_rd);
    assign mem_rs_hit = reg_match(id_rs, mem_rd);
    assign mem_rt_hit = reg_match(id_rt, mem_rd);

    assign load_use = ex_memread &&
                      ((id_uses_rs && ex_rs_hit) || (id_uses_rt && ex_rt_hit));

    // A branch compares in ID, so any EX result and a load still in MEM are too late.
    assign br_hazard = id_branch &&
                       ((ex_regwrite && (ex_rs_hit || ex_rt_hit)) ||
                        (mem_memread && (mem_rs_hit || mem_rt_hit)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/freeze control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : ID/EX/MEM hazard fields, branch outcome, dmem handshake in;
//                pc_write, ifid_write, bubble_sel, ifid_flush, pipe_freeze
//                (combinational, same-cycle), stall_cnt, mem_timeout out
// Priority: reset > memory freeze > hazard bubble > taken-branch flush.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    state_t                 state, state_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   mem_timeout;
    logic                   load_use, br_hazard, hazard_c, freeze_c;
    logic                   pc_write_c, ifid_write_c, bubble_sel_c;
    logic                   ifid_flush_c, pipe_freeze_c;

    hazard_cmp u_cmp (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rs  (bus.id_uses_rs),
        .id_uses_rt  (bus.id_uses_rt),
        .id_branch   (bus.id_branch),
        .ex_rd       (bus.ex_rd),
        .ex_regwrite (bus.ex_regwrite),
        .ex_memread  (bus.ex_memread),
        .mem_rd      (bus.mem_rd),
        .mem_memread (bus.mem_memread),
        .load_use    (load_use),
        .br_hazard   (br_hazard)
    );

    assign hazard_c = load_use || br_hazard;

    // Freeze starts in the very cycle the access misses, not one cycle later.
    assign freeze_c = ((state == MEM_WAIT) && !bus.dmem_ready) ||
                      ((state == RUN) && bus.dmem_req && !bus.dmem_ready);

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:      if (bus.dmem_req && !bus.dmem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (bus.dmem_ready)                  state_nxt = RUN;
            default:                                       state_nxt = RUN;
        endcase
    end

    // Pipeline control outputs; reset is folded in so the pipe is held while rst_n=0
    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        bubble_sel_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        pipe_freeze_c = 1'b0;
        if (!rst_n) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            bubble_sel_c = 1'b1;
        end else if (freeze_c) begin
            pipe_freeze_c = 1'b1;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
        end else if (hazard_c) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            bubble_sel_c = 1'b1;
        end else if (bus.branch_taken) begin
            ifid_flush_c = 1'b1;
        end
    end

    // FSM state, stall statistics and memory-wait watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!pc_write_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            if ((state == RUN) && (state_nxt == MEM_WAIT))
                wait_cnt <= '0;
            else if ((state == MEM_WAIT) && (wait_cnt != TIMEOUT_LIMIT))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            // Sticky: set on the edge the counter reaches the limit; FSM keeps waiting.
            if ((state == MEM_WAIT) && (wait_cnt == (TIMEOUT_LIMIT - WAIT_W'(1))))
                mem_timeout <= 1'b1;
        end
    end

    assign bus.pc_write    = pc_write_c;
    assign bus.ifid_write  = ifid_write_c;
    assign bus.bubble_sel  = bubble_sel_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.pipe_freeze = pipe_freeze_c;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                           input logic bub, input logic fl, input logic frz);
        check({tag, ".pc_write"},    32'(bus.pc_write),    32'(pcw));
        check({tag, ".ifid_write"},  32'(bus.ifid_write),  32'(ifw));
        check({tag, ".bubble_sel"},  32'(bus.bubble_sel),  32'(bub));
        check({tag, ".ifid_flush"},  32'(bus.ifid_flush),  32'(fl));
        check({tag, ".pipe_freeze"}, 32'(bus.pipe_freeze), 32'(frz));
    endtask

    task automatic clear_inputs();
        bus.id_rs = '0;        bus.id_rt = '0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_branch = 1'b0;
        bus.ex_rd = '0;        bus.mem_rd = '0;
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.mem_memread = 1'b0;
        bus.branch_taken = 1'b0;
        bus.dmem_req = 1'b0;   bus.dmem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drive_load_use_r5();
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs = 5'd5;      bus.id_uses_rs = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        // Reset values and forced outputs while rst_n=0
        chk_ctl("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst.stall_cnt",   32'(bus.stall_cnt),   32'd0);
        check("rst.mem_timeout", 32'(bus.mem_timeout), 32'd0);
        check("rst.state",       32'(dut.state),       32'd0);
        do_reset();
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Load-use on rs: one bubble cycle
        drive_load_use_r5();
        #1;
        chk_ctl("lu", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("lu.stall_cnt", 32'(bus.stall_cnt), 32'd1);
        clear_inputs();
        bus.mem_rd = 5'd5; bus.mem_memread = 1'b1; bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        #1;
        chk_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("lu_after.stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Source not read: no load-use
        clear_inputs();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b0;
        #1;
        chk_ctl("lu_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Register 0 never hazards (load-use and branch)
        clear_inputs();
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1; bus.id_branch = 1'b1;
        bus.mem_rd = 5'd0; bus.mem_memread = 1'b1;
        #1;
        chk_ctl("r0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("r0.stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // Load then branch on rt=7: EX match, MEM match, then taken flush
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd7;
        bus.id_branch = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd7;
        bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1; bus.branch_taken = 1'b1;
        #1;
        chk_ctl("lb1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0;
        bus.mem_memread = 1'b1; bus.mem_rd = 5'd7;
        #1;
        chk_ctl("lb2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("lb2.stall_cnt", 32'(bus.stall_cnt), 32'd2);
        bus.mem_memread = 1'b0; bus.mem_rd = 5'd0;
        #1;
        chk_ctl("lb_flush", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check("lb_flush.stall_cnt", 32'(bus.stall_cnt), 32'd2);

        // ALU result in EX feeding a branch stalls; non-load in MEM does not
        clear_inputs();
        bus.id_branch = 1'b1; bus.id_rs = 5'd12; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd12;
        #1;
        chk_ctl("br_alu_ex", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.ex_regwrite = 1'b0; bus.ex_rd = 5'd0; bus.mem_rd = 5'd12; bus.mem_memread = 1'b0;
        #1;
        chk_ctl("br_alu_mem", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Memory freeze for 4 cycles with a concurrent load-use that must be masked
        do_reset();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        drive_load_use_r5();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctl($sformatf("frz%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
        end
        check("frz.state",     32'(dut.state),     32'd1);
        check("frz.stall_cnt", 32'(bus.stall_cnt), 32'd4);
        bus.dmem_ready = 1'b1;
        #1;
        chk_ctl("frz_ready", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("frz_exit.state",     32'(dut.state),     32'd0);
        check("frz_exit.stall_cnt", 32'(bus.stall_cnt), 32'd5);
        clear_inputs();
        #1;
        chk_ctl("frz_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Watchdog: 300 cycles with dmem_ready low
        do_reset();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        step();
        check("to.enter_state", 32'(dut.state),    32'd1);
        check("to.enter_wait",  32'(dut.wait_cnt), 32'd0);
        repeat (254) step();
        check("to.at254",      32'(bus.mem_timeout), 32'd0);
        check("to.wait254",    32'(dut.wait_cnt),    32'd254);
        step();
        check("to.at255",      32'(bus.mem_timeout), 32'd1);
        repeat (44) step();
        check("to.hold",       32'(bus.mem_timeout), 32'd1);
        check("to.hold_state", 32'(dut.state),       32'd1);
        check("to.hold_frz",   32'(bus.pipe_freeze), 32'd1);
        bus.dmem_ready = 1'b1;
        step();
        check("to.exit_state", 32'(dut.state),       32'd0);
        check("to.sticky",     32'(bus.mem_timeout), 32'd1);
        clear_inputs();
        step();
        check("to.sticky2",    32'(bus.mem_timeout), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("to.rst_clear",  32'(bus.mem_timeout), 32'd0);
        do_reset();

        // Asynchronous reset in the middle of MEM_WAIT
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        step();
        step();
        check("ar.pre_state", 32'(dut.state),     32'd1);
        check("ar.pre_wait",  32'(dut.wait_cnt),  32'd1);
        check("ar.pre_stall", 32'(bus.stall_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.state",       32'(dut.state),       32'd0);
        check("ar.stall_cnt",   32'(bus.stall_cnt),   32'd0);
        check("ar.wait_cnt",    32'(dut.wait_cnt),    32'd0);
        check("ar.mem_timeout", 32'(bus.mem_timeout), 32'd0);
        chk_ctl("ar", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        step();
        check("ar.run_after", 32'(dut.state), 32'd0);

        // stall_cnt saturation under a sustained stall
        do_reset();
        drive_load_use_r5();
        repeat (65534) step();
        check("sat.fffe", 32'(bus.stall_cnt), 32'h0000_FFFE);
        step();
        check("sat.ffff", 32'(bus.stall_cnt), 32'h0000_FFFF);
        repeat (3) step();
        check("sat.hold", 32'(bus.stall_cnt), 32'h0000_FFFF);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
